wbuf_axi_drain: RTL and testbench
=================================

// Module: wbuf_axi_drain
// PURPOSE
//  Drain stage downstream of the dcache write-buffer FIFO. Peeks the FIFO head
//  entry {addr, data, strb}, issues it as one single-beat AXI4 write (AW+W),
//  waits for B, then pops the entry. Writes leave strictly in FIFO order, one
//  outstanding at a time. Reports drain-idle status to the LSU for dbar/ibar.
// PARAMETERS
//  ADDR_WIDTH   32     byte address width of an entry and of awaddr
//  DATA_WIDTH   32     data width of an entry and of wdata; STRB = DATA_WIDTH/8
//  AXI_ID       4'h1   constant awid driven on every write
//  ENTRY_WIDTH  ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8  packed {addr,data,strb}
// PORTS
//  clk            in   1            clock
//  reset          in   1            synchronous, active-high
//  fifo_not_empty in   1            FIFO holds >=1 valid entry
//  fifo_head      in   ENTRY_WIDTH  head entry; valid only while fifo_rd_en=1
//  fifo_rd_en     out  1            peek request (FIFO dequeue enable)
//  fifo_pop       out  1            one-cycle pulse: invalidate/advance head
//  awaddr         out  ADDR_WIDTH   write address
//  awid           out  4            = AXI_ID
//  awlen/awsize   out  8/3          0 / log2(STRB): single beat, full width
//  awburst        out  2            2'b01 INCR
//  awvalid/awready out/in 1         AW handshake
//  wdata/wstrb    out  DATA_WIDTH/STRB  write data / byte enables
//  wlast          out  1            constant 1
//  wvalid/wready  out/in 1          W handshake
//  bresp          in   2            write response
//  bvalid/bready  in/out 1          B handshake
//  drain_idle     out  1            FSM IDLE and !fifo_not_empty
//  bus_err        out  1            sticky: some bresp != 2'b00
// BEHAVIOUR
//  Reset: FSM->IDLE; awvalid, wvalid, bready, fifo_pop, bus_err = 0;
//   fifo_rd_en = 0; captured entry regs = 0; drain_idle = !fifo_not_empty.
//  FSM states IDLE, SEND, WAIT_B, POP:
//   IDLE:   fifo_rd_en = fifo_not_empty (comb). If fifo_not_empty, capture
//           fifo_head into addr/data/strb regs at edge; -> SEND.
//   SEND:   awvalid=1 until AW handshake; wvalid=1 until W handshake; each
//           tracked by its own done flag; AW and W may complete in either
//           order or same cycle. Both done -> WAIT_B. AXI outputs driven only
//           from captured regs, stable while valid high.
//   WAIT_B: bready=1. On bvalid: if bresp!=0 set bus_err; -> POP.
//           bready also held 1 in SEND once both done flags set (no lost B).
//   POP:    fifo_pop=1 for exactly this cycle; -> IDLE. New head visible
//           in IDLE next cycle; no entry ever issued twice.
//  Minimum throughput with zero-wait slave: 1 entry / 4 cycles
//   (IDLE capture, SEND, WAIT_B, POP).
//  Error entries are still popped; no retry. bus_err clears only on reset.
//  reset mid-transaction: FSM aborts to IDLE at once; the entry is NOT popped
//   (FIFO is reset in the same cycle by the same reset).
//  fifo_not_empty dropping while in SEND/WAIT_B is ignored (entry captured).
//  awaddr passed through unaligned-as-is; strb selects bytes.
// CONFIGURATION
//  WBUF_DRAIN_PERF_EN defined: adds outputs perf_wr_cnt[31:0] (+1 per POP)
//   and perf_stall_cnt[31:0] (+1 per cycle in SEND/WAIT_B with no handshake
//   that cycle); both reset to 0, wrap at 2^32.
//  Not defined: ports and counters absent; other behaviour identical.
// TESTING
//  1 reset, empty FIFO -> all valids 0, fifo_pop 0, drain_idle=1, bus_err=0.
//  2 one entry {0x1C00_0100,0xDEAD_BEEF,4'hF}, ready slave -> awaddr=0x1C000100,
//    wdata=0xDEADBEEF, wstrb=F, wlast=1; fifo_pop pulses once 3 cycles
//    after capture; drain_idle=1 afterwards.
//  3 wready 2 cycles before awready (awready delayed 5) -> wvalid drops
//    after W handshake, awvalid held stable; exactly one AW, one W, one pop.
//  4 three entries back-to-back, strb 1,3,C -> AXI writes in FIFO order with
//    matching strb, 3 pops, no duplicated or skipped entry.
//  5 bresp=2'b10 on 2nd of 2 writes -> bus_err=1 after that B, both popped,
//    bus_err stays 1 until reset.
//  6 reset asserted in WAIT_B -> next cycle IDLE, bready=0, no fifo_pop;
//    with PERF_EN, perf_wr_cnt=0 after reset, =2 after scenario 5.

Source files
------------

// File: rtl/wbuf_axi_drain.sv
// Write-buffer drain: issues the FIFO head entry as a single-beat AXI4 write and pops it after B.
// Define WBUF_DRAIN_PERF_EN to add the perf_wr_cnt / perf_stall_cnt performance counters.
module wbuf_axi_drain #(
    parameter int         ADDR_WIDTH  = 32,
    parameter int         DATA_WIDTH  = 32,
    parameter logic [3:0] AXI_ID      = 4'h1,
    parameter int         ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fifo_not_empty,
    input  logic [ENTRY_WIDTH-1:0]    fifo_head,
    output logic                      fifo_rd_en,
    output logic                      fifo_pop,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [3:0]                awid,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic                      drain_idle,
    output logic                      bus_err
`ifdef WBUF_DRAIN_PERF_EN
    ,
    output logic [31:0]               perf_wr_cnt,
    output logic [31:0]               perf_stall_cnt
`endif
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] AW_SIZE    = 3'($clog2(STRB_WIDTH));

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_B,
        POP
    } state_t;

    state_t                  state;
    logic                    aw_done;
    logic                    w_done;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [STRB_WIDTH-1:0]   strb_q;

    logic aw_hs;
    logic w_hs;
    logic b_hs;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;

    // The head entry is only presented while we peek in IDLE.
    assign fifo_rd_en = (state == IDLE) && fifo_not_empty;
    assign drain_idle = (state == IDLE) && !fifo_not_empty;

    // AXI payload comes only from the captured entry, so it stays stable while valid is high.
    assign awaddr  = addr_q;
    assign awid    = AXI_ID;
    assign awlen   = 8'd0;
    assign awsize  = AW_SIZE;
    assign awburst = 2'b01;
    assign wdata   = data_q;
    assign wstrb   = strb_q;
    assign wlast   = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            fifo_pop <= 1'b0;
            bus_err  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
        end else begin
            // NOTE: every register here uses <= so all next-state terms see the pre-edge values.
            fifo_pop <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_not_empty) begin
                        {addr_q, data_q, strb_q} <= fifo_head;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (aw_hs) awvalid <= 1'b0;
                    if (w_hs)  wvalid  <= 1'b0;
                    aw_done <= aw_done || aw_hs;
                    w_done  <= w_done || w_hs;
                    // bready rises together with the last address/data handshake, so no B is missed.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready <= 1'b1;
                        state  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (b_hs) begin
                        bready   <= 1'b0;
                        fifo_pop <= 1'b1;
                        if (bresp != 2'b00) bus_err <= 1'b1;
                        state    <= POP;
                    end
                end
                POP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WBUF_DRAIN_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_wr_cnt    <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (state == POP) perf_wr_cnt <= perf_wr_cnt + 32'd1;
            if ((state == SEND || state == WAIT_B) && !(aw_hs || w_hs || b_hs))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wbuf_axi_drain.sv
// Self-checking bench for wbuf_axi_drain: queue-based FIFO, randomised AXI slave and an in-order write model.
`timescale 1ns/1ps
module tb_wbuf_axi_drain;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_not_empty;
    logic [67:0] fifo_head;
    logic        fifo_rd_en;
    logic        fifo_pop;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        drain_idle;
    logic        bus_err;
`ifdef WBUF_DRAIN_PERF_EN
    logic [31:0] perf_wr_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    wbuf_axi_drain dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_not_empty (fifo_not_empty),
        .fifo_head      (fifo_head),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_pop       (fifo_pop),
        .awaddr         (awaddr),
        .awid           (awid),
        .awlen          (awlen),
        .awsize         (awsize),
        .awburst        (awburst),
        .awvalid        (awvalid),
        .awready        (awready),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .wlast          (wlast),
        .wvalid         (wvalid),
        .wready         (wready),
        .bresp          (bresp),
        .bvalid         (bvalid),
        .bready         (bready),
        .drain_idle     (drain_idle),
        .bus_err        (bus_err)
`ifdef WBUF_DRAIN_PERF_EN
        ,
        .perf_wr_cnt    (perf_wr_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Reference state: the FIFO contents, the expected write order and the slave's responses.
    entry_t      fifo_q[$];
    entry_t      exp_q[$];
    logic [1:0]  resp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    int cap_cycle = 0;
    int n_aw = 0, n_w = 0, n_pop = 0;
    int pops_since_reset = 0;
    int exp_stall = 0;
    int aw_delay = 0, w_delay = 0, b_delay = 0;
    int aw_cnt = 0, w_cnt = 0, b_timer = 0;
    bit rst_q = 1'b1;
    bit check_lat = 1'b0;
    bit rand_mode = 1'b0;
    bit busy = 1'b0;
    bit cur_aw = 1'b0, cur_w = 1'b0, cur_b = 1'b0;
    bit aw_pend = 1'b0, w_pend = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] aw_hold;
    logic [35:0] w_hold;

    // FIFO + AXI slave + protocol monitor: samples at negedge, drives 1ns after posedge.
    initial begin : bus
        bit aw_hs, w_hs, b_hs, pop_seen, cap_seen, err_seen;
        awready = 1'b0;
        wready = 1'b0;
        bvalid = 1'b0;
        bresp = 2'b00;
        fifo_not_empty = 1'b0;
        fifo_head = '0;
        err_seen = 1'b0;
        forever begin
            @(negedge clk);
            cycle++;
            aw_hs    = awvalid && awready;
            w_hs     = wvalid && wready;
            b_hs     = bvalid && bready;
            pop_seen = fifo_pop;
            cap_seen = fifo_rd_en;
            if (!rst_q) begin
                if (aw_pend) begin
                    n_checks++;
                    if (awvalid !== 1'b1 || awaddr !== aw_hold)
                        $display("FAIL aw_stable: awvalid=%b awaddr=%h, required 1 / %h", awvalid, awaddr, aw_hold);
                    else n_pass++;
                end
                if (w_pend) begin
                    n_checks++;
                    if (wvalid !== 1'b1 || {wdata, wstrb} !== w_hold)
                        $display("FAIL w_stable: wvalid=%b w=%h, required 1 / %h", wvalid, {wdata, wstrb}, w_hold);
                    else n_pass++;
                end
                if (aw_hs) begin
                    n_aw++;
                    n_checks++;
                    if (exp_q.size() == 0 || cur_aw)
                        $display("FAIL aw_unexpected: awaddr=%h with %0d queued, required no AW", awaddr, exp_q.size());
                    else if ({awaddr, awid, awlen, awsize, awburst} !== {exp_q[0].addr, 4'h1, 8'h00, 3'd2, 2'b01})
                        $display("FAIL aw_fields: got %h, required %h", {awaddr, awid, awlen, awsize, awburst},
                                 {exp_q[0].addr, 4'h1, 8'h00, 3'd2, 2'b01});
                    else n_pass++;
                    cur_aw = 1'b1;
                end
                if (w_hs) begin
                    n_w++;
                    n_checks++;
                    if (exp_q.size() == 0 || cur_w)
                        $display("FAIL w_unexpected: wdata=%h with %0d queued, required no W", wdata, exp_q.size());
                    else if ({wdata, wstrb, wlast} !== {exp_q[0].data, exp_q[0].strb, 1'b1})
                        $display("FAIL w_fields: got %h, required %h", {wdata, wstrb, wlast},
                                 {exp_q[0].data, exp_q[0].strb, 1'b1});
                    else n_pass++;
                    cur_w = 1'b1;
                end
                if (bready) begin
                    n_checks++;
                    if (!(cur_aw && cur_w) || cur_b)
                        $display("FAIL bready_window: bready=1 with aw/w/b done=%b%b%b, required 110", cur_aw, cur_w, cur_b);
                    else n_pass++;
                end
                if (b_hs) begin
                    cur_b = 1'b1;
                    err_seen = (bresp != 2'b00);
                end
                if (pop_seen) begin
                    n_checks++;
                    if ({cur_aw, cur_w, cur_b} !== 3'b111)
                        $display("FAIL pop_early: aw/w/b done=%b%b%b, required 111", cur_aw, cur_w, cur_b);
                    else if (check_lat && (cycle - cap_cycle) != 3)
                        $display("FAIL pop_latency: %0d cycles after capture, required 3", cycle - cap_cycle);
                    else n_pass++;
                end
                if (cap_seen) begin
                    n_checks++;
                    if (busy || !fifo_not_empty)
                        $display("FAIL capture: fifo_rd_en=1 with busy=%b not_empty=%b, required 0/1", busy, fifo_not_empty);
                    else n_pass++;
                    cap_cycle = cycle;
                end
                n_checks++;
                if (bus_err !== exp_err)
                    $display("FAIL bus_err: got %b, required %b", bus_err, exp_err);
                else n_pass++;
                if (busy && !(aw_hs || w_hs || b_hs)) exp_stall++;
            end
            aw_pend = awvalid && !awready;
            w_pend  = wvalid && !wready;
            aw_hold = awaddr;
            w_hold  = {wdata, wstrb};
            if (aw_hs) aw_cnt = 0; else if (awvalid) aw_cnt++;
            if (w_hs)  w_cnt = 0;  else if (wvalid)  w_cnt++;

            @(posedge clk);
            #1;
            rst_q = reset;
            if (reset) begin
                fifo_q.delete();
                exp_q.delete();
                resp_q.delete();
                {cur_aw, cur_w, cur_b, busy, aw_pend, w_pend} = '0;
                exp_err = 1'b0;
                exp_stall = 0;
                pops_since_reset = 0;
                bvalid = 1'b0;
                bresp = 2'b00;
                b_timer = 0;
                aw_cnt = 0;
                w_cnt = 0;
            end else begin
                if (b_hs) begin
                    bvalid = 1'b0;
                    exp_err = exp_err | err_seen;
                    busy = 1'b0;
                end
                if (pop_seen) begin
                    if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    {cur_aw, cur_w, cur_b} = 3'b000;
                    b_timer = 0;
                    pops_since_reset++;
                    n_pop++;
                    if (rand_mode) begin
                        aw_delay = $urandom_range(0, 4);
                        w_delay  = $urandom_range(0, 4);
                        b_delay  = $urandom_range(0, 3);
                    end
                end
                if (cap_seen) busy = 1'b1;
                if (cur_aw && cur_w && !cur_b && !bvalid) begin
                    if (b_timer >= b_delay) begin
                        bvalid = 1'b1;
                        bresp = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
                    end else begin
                        b_timer++;
                    end
                end
            end
            awready = (aw_cnt >= aw_delay);
            wready  = (w_cnt >= w_delay);
            fifo_not_empty = (fifo_q.size() > 0);
            fifo_head = fifo_not_empty ? fifo_q[0] : {$urandom, $urandom, 4'($urandom)};
        end
    end

    task automatic push(input entry_t e, input logic [1:0] r);
        fifo_q.push_back(e);
        exp_q.push_back(e);
        resp_q.push_back(r);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int  k;
        bit  done;
        k = 0;
        done = 1'b0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
            done = (fifo_q.size() == 0) && !busy && (drain_idle === 1'b1);
        end
        n_checks++;
        if (!done)
            $display("FAIL drain_timeout: %0d entries left, drain_idle=%b after %0d cycles, required empty and 1",
                     fifo_q.size(), drain_idle, k);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({awvalid, wvalid, bready, fifo_pop, fifo_rd_en} !== 5'b00000)
            $display("FAIL reset_outputs: aw/w/b/pop/rd=%b, required 00000",
                     {awvalid, wvalid, bready, fifo_pop, fifo_rd_en});
        else n_pass++;
        n_checks++;
        if ({drain_idle, bus_err} !== 2'b10)
            $display("FAIL reset_status: drain_idle/bus_err=%b, required 10", {drain_idle, bus_err});
        else n_pass++;
`ifdef WBUF_DRAIN_PERF_EN
        n_checks++;
        if ({perf_wr_cnt, perf_stall_cnt} !== 64'd0)
            $display("FAIL reset_perf: wr=%0d stall=%0d, required 0/0", perf_wr_cnt, perf_stall_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_single();
        int p0;
        p0 = n_pop;
        check_lat = 1'b1;
        push({32'h1C00_0100, 32'hDEAD_BEEF, 4'hF}, 2'b00);
        wait_drain(100);
        check_lat = 1'b0;
        n_checks++;
        if (n_pop - p0 != 1)
            $display("FAIL single_pops: %0d pops, required 1", n_pop - p0);
        else n_pass++;
    endtask

    task automatic test_aw_late();
        int a0, w0, p0, k;
        a0 = n_aw;
        w0 = n_w;
        p0 = n_pop;
        aw_delay = 5;
        w_delay  = 3;
        push({32'h0000_1003, 32'h0BAD_F00D, 4'h6}, 2'b00);
        k = 0;
        while (n_w == w0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        n_checks++;
        if ({wvalid, awvalid} !== 2'b01)
            $display("FAIL aw_late_valids: wvalid/awvalid=%b after W handshake, required 01", {wvalid, awvalid});
        else n_pass++;
        wait_drain(100);
        n_checks++;
        if (n_aw - a0 != 1 || n_w - w0 != 1 || n_pop - p0 != 1)
            $display("FAIL aw_late_counts: aw=%0d w=%0d pop=%0d, required 1/1/1", n_aw - a0, n_w - w0, n_pop - p0);
        else n_pass++;
        aw_delay = 0;
        w_delay  = 0;
    endtask

    task automatic test_back_to_back();
        int     p0;
        entry_t e;
        logic [3:0] strbs [3];
        strbs[0] = 4'h1;
        strbs[1] = 4'h3;
        strbs[2] = 4'hC;
        p0 = n_pop;
        check_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e.addr = $urandom;
            e.data = $urandom;
            e.strb = strbs[i];
            push(e, 2'b00);
        end
        wait_drain(100);
        check_lat = 1'b0;
        n_checks++;
        if (n_pop - p0 != 3)
            $display("FAIL b2b_pops: %0d pops, required 3", n_pop - p0);
        else n_pass++;
    endtask

    task automatic test_bus_err();
        apply_reset();
        push({32'h2000_0000, 32'h1111_1111, 4'hF}, 2'b00);
        wait_drain(100);
        n_checks++;
        if (bus_err !== 1'b0)
            $display("FAIL err_after_okay: bus_err=%b, required 0", bus_err);
        else n_pass++;
        push({32'h2000_0004, 32'h2222_2222, 4'h5}, 2'b10);
        wait_drain(100);
        n_checks++;
        if (bus_err !== 1'b1 || pops_since_reset != 2)
            $display("FAIL err_after_slverr: bus_err=%b pops=%0d, required 1/2", bus_err, pops_since_reset);
        else n_pass++;
`ifdef WBUF_DRAIN_PERF_EN
        n_checks++;
        if (perf_wr_cnt !== 32'd2)
            $display("FAIL perf_wr_after_err: %0d, required 2", perf_wr_cnt);
        else n_pass++;
`endif
        push({32'h2000_0008, 32'h3333_3333, 4'hF}, 2'b00);
        wait_drain(100);
        n_checks++;
        if (bus_err !== 1'b1)
            $display("FAIL err_sticky: bus_err=%b, required 1", bus_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k;
        b_delay = 20;
        push({32'h3000_0010, 32'hCAFE_0001, 4'hF}, 2'b00);
        k = 0;
        while (!(cur_aw && cur_w) && k < 100) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        n_checks++;
        if (bready !== 1'b1)
            $display("FAIL mid_wait_b: bready=%b, required 1", bready);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({awvalid, wvalid, bready, fifo_pop, bus_err, drain_idle} !== 6'b000001)
            $display("FAIL mid_reset: aw/w/b/pop/err/idle=%b, required 000001",
                     {awvalid, wvalid, bready, fifo_pop, bus_err, drain_idle});
        else n_pass++;
`ifdef WBUF_DRAIN_PERF_EN
        n_checks++;
        if (perf_wr_cnt !== 32'd0)
            $display("FAIL mid_perf_wr: %0d, required 0", perf_wr_cnt);
        else n_pass++;
`endif
        b_delay = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_random();
        int     p0;
        int     pushed;
        entry_t e;
        p0 = n_pop;
        pushed = 0;
        rand_mode = 1'b1;
        while (pushed < 40) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                e.addr = $urandom;
                e.data = $urandom;
                e.strb = 4'($urandom_range(1, 15));
                push(e, ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'b00);
                pushed++;
            end
        end
        wait_drain(3000);
        rand_mode = 1'b0;
        n_checks++;
        if (n_pop - p0 != 40)
            $display("FAIL random_pops: %0d pops, required 40", n_pop - p0);
        else n_pass++;
`ifdef WBUF_DRAIN_PERF_EN
        n_checks++;
        if (perf_wr_cnt !== 32'(pops_since_reset) || perf_stall_cnt !== 32'(exp_stall))
            $display("FAIL random_perf: wr=%0d stall=%0d, required %0d/%0d",
                     perf_wr_cnt, perf_stall_cnt, pops_since_reset, exp_stall);
        else n_pass++;
`endif
        aw_delay = 0;
        w_delay  = 0;
        b_delay  = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_aw_late();
        test_back_to_back();
        test_bus_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
